// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding, display-counter codes and LFSR taps
// for the multi-player reaction arbiter.
package reaction_pkg;
    typedef enum logic [1:0] {IDLE, ARM, GO, RESULT} state_t;
    localparam logic [1:0] CF_CLEAR = 2'b00;
    localparam logic [1:0] CF_HOLD = 2'b01;
    localparam logic [1:0] CF_RUN = 2'b10;
    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
endpackage

// File: rtl/lfsr32.sv
// lfsr32: free-running 32-bit Galois LFSR, seeded to 1 by async reset.
module lfsr32 import reaction_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] q
);
    logic [31:0] q_q, q_d;
    always_comb q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_TAPS : 32'h0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 32'h1;
        else q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/reaction_arbiter.sv
// reaction_arbiter: multi-player reaction timer; arms on start, lights the go
// lamp after a pseudo-random delay and reports the first eligible stop.
module reaction_arbiter import reaction_pkg::*; #(
    parameter int PLAYERS = 4,
    parameter int CNT_W = 32,
    parameter int DELAY_MIN = 100000000,
    parameter int DELAY_SPAN = 200000000,
    parameter int TIMEOUT_CYC = 500000000,
    localparam int ID_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic               clk_50M,
    input  logic               clear,
    input  logic               start,
    input  logic [PLAYERS-1:0] stop,
    output logic [1:0]         CounterFlag,
    output logic               LED,
    output logic               LED_InRuning,
    output logic [PLAYERS-1:0] false_start,
    output logic               winner_valid,
    output logic [ID_W-1:0]    winner_id,
    output logic [CNT_W-1:0]   react_cyc,
    output logic               timeout,
    output logic               done
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, delay_q, delay_d, react_q, react_d, cnt_inc;
    logic [PLAYERS-1:0] stop_prev_q, fs_q, fs_d, stop_edge, elig;
    logic [ID_W-1:0] wid_q, wid_d, first_id;
    logic [1:0] cf_q, cf_d;
    logic [31:0] lfsr;
    logic start_prev_q, start_edge;
    logic wv_q, wv_d, to_q, to_d, done_q, done_d, led_q, led_d, run_q, run_d;

    lfsr32 u_lfsr (.clk(clk_50M), .rst(clear), .q(lfsr));

    assign start_edge = start & ~start_prev_q;
    assign stop_edge = stop & ~stop_prev_q;
    assign elig = stop_edge & ~fs_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        first_id = '0;
        for (int i = PLAYERS - 1; i >= 0; i--) if (elig[i]) first_id = ID_W'(i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        delay_d = delay_q;
        react_d = react_q;
        fs_d = fs_q;
        wid_d = wid_q;
        wv_d = wv_q;
        to_d = to_q;
        led_d = led_q;
        run_d = run_q;
        cf_d = cf_q;
        done_d = 1'b0;
        case (state_q)
            IDLE, RESULT: if (start_edge) begin
                state_d = ARM;
                fs_d = '0;
                wv_d = 1'b0;
                to_d = 1'b0;
                react_d = '0;
                delay_d = CNT_W'(DELAY_MIN) + CNT_W'(lfsr % 32'(DELAY_SPAN));
                cnt_d = '0;
                cf_d = CF_CLEAR;
                run_d = 1'b1;
            end
            ARM: begin
                cnt_d = cnt_inc;
                fs_d = fs_q | stop_edge;
                // A full house of false starts beats a coincident delay expiry
                if (&fs_d) begin
                    state_d = RESULT;
                    done_d = 1'b1;
                    cf_d = CF_HOLD;
                    run_d = 1'b0;
                end else if (cnt_inc == delay_q) begin
                    state_d = GO;
                    led_d = 1'b1;
                    cf_d = CF_RUN;
                    cnt_d = '0;
                end
            end
            GO: begin
                cnt_d = cnt_inc;
                if (|elig || cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    state_d = RESULT;
                    wv_d = |elig;
                    to_d = ~|elig;
                    react_d = |elig ? cnt_inc : react_q;
                    wid_d = |elig ? first_id : wid_q;
                    led_d = 1'b0;
                    cf_d = CF_HOLD;
                    run_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q <= '0;
            delay_q <= '0;
            react_q <= '0;
            fs_q <= '0;
            wid_q <= '0;
            wv_q <= 1'b0;
            to_q <= 1'b0;
            led_q <= 1'b0;
            run_q <= 1'b0;
            cf_q <= CF_CLEAR;
            done_q <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            delay_q <= delay_d;
            react_q <= react_d;
            fs_q <= fs_d;
            wid_q <= wid_d;
            wv_q <= wv_d;
            to_q <= to_d;
            led_q <= led_d;
            run_q <= run_d;
            cf_q <= cf_d;
            done_q <= done_d;
            start_prev_q <= start;
            stop_prev_q <= stop;
        end
    end

    assign CounterFlag = cf_q;
    assign LED = led_q;
    assign LED_InRuning = run_q;
    assign false_start = fs_q;
    assign winner_valid = wv_q;
    assign winner_id = wid_q;
    assign react_cyc = react_q;
    assign timeout = to_q;
    assign done = done_q;
endmodule

// File: tb/tb_reaction_arbiter.sv
// tb_reaction_arbiter: randomized scenario bench for reaction_arbiter with a
// round-level reference model (delay from a tracked LFSR, winner by rules).
module tb_reaction_arbiter;
    logic clk_50M = 1'b0, clear = 1'b0, start = 1'b0;
    logic [3:0] stop = 4'b0;
    logic [1:0] CounterFlag, winner_id;
    logic LED, LED_InRuning, winner_valid, timeout, done;
    logic [3:0] false_start;
    logic [31:0] react_cyc, m_lfsr;
    int errors = 0, checks = 0, cyc = 0, t_start = 0, t_go = 0;

    reaction_arbiter #(.PLAYERS(4), .CNT_W(32), .DELAY_MIN(10), .DELAY_SPAN(4), .TIMEOUT_CYC(50)) dut (
        .clk_50M(clk_50M), .clear(clear), .start(start), .stop(stop),
        .CounterFlag(CounterFlag), .LED(LED), .LED_InRuning(LED_InRuning),
        .false_start(false_start), .winner_valid(winner_valid), .winner_id(winner_id),
        .react_cyc(react_cyc), .timeout(timeout), .done(done)
    );

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] fb;
        fb = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
        return (v >> 1) ^ (v[0] ? fb : 32'h0);
    endfunction

    always @(posedge clk_50M or posedge clear) m_lfsr <= clear ? 32'h1 : lfsr_next(m_lfsr);

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic press(input logic [3:0] m);
        stop = m;
        @(negedge clk_50M);
        stop = 4'b0;
    endtask

    task automatic begin_round(output int d);
        @(negedge clk_50M);
        d = 10 + int'(m_lfsr % 32'd4);
        start = 1'b1;
        @(negedge clk_50M);
        start = 1'b0;
        t_start = cyc;
        checks++; if (CounterFlag !== 2'b00) begin errors++; $display("FAIL arm_cf: got %b want 00", CounterFlag); end
        checks++; if (LED_InRuning !== 1'b1 || LED !== 1'b0) begin errors++; $display("FAIL arm_lamps: got run=%b led=%b want run=1 led=0", LED_InRuning, LED); end
        checks++; if (winner_valid !== 1'b0 || timeout !== 1'b0 || false_start !== 4'b0 || react_cyc !== 32'd0) begin
            errors++; $display("FAIL arm_clear: got wv=%b to=%b fs=%b react=%0d want all 0", winner_valid, timeout, false_start, react_cyc);
        end
    endtask

    task automatic wait_go(input int d);
        int n = 0;
        while (LED !== 1'b1 && n < 40) begin
            @(negedge clk_50M);
            n++;
            checks++; if (LED_InRuning !== 1'b1) begin errors++; $display("FAIL arm_running: got %b want 1", LED_InRuning); end
        end
        t_go = cyc;
        checks++; if (cyc - t_start != d) begin errors++; $display("FAIL go_latency: got %0d want %0d", cyc - t_start, d); end
        checks++; if (CounterFlag !== 2'b10) begin errors++; $display("FAIL go_cf: got %b want 10", CounterFlag); end
    endtask

    task automatic test_reset();
        int d;
        #5 clear = 1'b1;
        #3;
        checks++; if ({CounterFlag, LED, LED_InRuning, false_start, winner_valid, winner_id, react_cyc, timeout, done} !== '0) begin
            errors++; $display("FAIL reset_outputs: got cf=%b led=%b run=%b fs=%b wv=%b id=%0d react=%0d to=%b done=%b want all 0",
                CounterFlag, LED, LED_InRuning, false_start, winner_valid, winner_id, react_cyc, timeout, done);
        end
        @(negedge clk_50M);
        clear = 1'b0;
        begin_round(d);
        wait_go(d);
    endtask

    task automatic test_single_winner();
        start = 1'b1;
        @(negedge clk_50M);
        start = 1'b0;
        checks++; if (LED !== 1'b1 || CounterFlag !== 2'b10) begin errors++; $display("FAIL start_in_go: got led=%b cf=%b want 1 10", LED, CounterFlag); end
        @(negedge clk_50M);
        press(4'b0100);
        checks++; if (react_cyc !== 32'd3) begin errors++; $display("FAIL single_react: got %0d want 3", react_cyc); end
        checks++; if (winner_id !== 2'd2 || winner_valid !== 1'b1) begin errors++; $display("FAIL single_winner: got id=%0d wv=%b want 2 1", winner_id, winner_valid); end
        checks++; if (done !== 1'b1 || CounterFlag !== 2'b01 || LED !== 1'b0 || LED_InRuning !== 1'b0) begin
            errors++; $display("FAIL single_result: got done=%b cf=%b led=%b run=%b want 1 01 0 0", done, CounterFlag, LED, LED_InRuning);
        end
        press(4'b0001);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
        checks++; if (winner_id !== 2'd2 || react_cyc !== 32'd3 || winner_valid !== 1'b1) begin
            errors++; $display("FAIL result_hold: got id=%0d react=%0d wv=%b want 2 3 1", winner_id, react_cyc, winner_valid);
        end
    endtask

    task automatic test_false_start();
        int d;
        begin_round(d);
        press(4'b0010);
        checks++; if (false_start !== 4'b0010 || LED_InRuning !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL fs_flag: got fs=%b run=%b done=%b want 0010 1 0", false_start, LED_InRuning, done);
        end
        wait_go(d);
        press(4'b1010);
        checks++; if (winner_id !== 2'd3 || winner_valid !== 1'b1 || react_cyc !== 32'd1) begin
            errors++; $display("FAIL fs_winner: got id=%0d wv=%b react=%0d want 3 1 1", winner_id, winner_valid, react_cyc);
        end
        checks++; if (false_start !== 4'b0010) begin errors++; $display("FAIL fs_sticky: got %b want 0010", false_start); end
    endtask

    task automatic test_simultaneous();
        int d, k;
        begin_round(d);
        wait_go(d);
        k = $urandom_range(1, 10);
        repeat (k - 1) @(negedge clk_50M);
        press(4'b0101);
        checks++; if (winner_id !== 2'd0 || react_cyc !== 32'(k)) begin
            errors++; $display("FAIL simul_winner: got id=%0d react=%0d want 0 %0d", winner_id, react_cyc, k);
        end
    endtask

    task automatic test_all_false();
        int d, lit = 0;
        begin_round(d);
        press(4'b0011);
        checks++; if (false_start !== 4'b0011 || done !== 1'b0 || LED_InRuning !== 1'b1) begin
            errors++; $display("FAIL allfs_partial: got fs=%b done=%b run=%b want 0011 0 1", false_start, done, LED_InRuning);
        end
        press(4'b1100);
        checks++; if (done !== 1'b1 || winner_valid !== 1'b0 || timeout !== 1'b0 || false_start !== 4'b1111) begin
            errors++; $display("FAIL allfs_result: got done=%b wv=%b to=%b fs=%b want 1 0 0 1111", done, winner_valid, timeout, false_start);
        end
        checks++; if (CounterFlag !== 2'b01 || LED_InRuning !== 1'b0) begin errors++; $display("FAIL allfs_cf: got cf=%b run=%b want 01 0", CounterFlag, LED_InRuning); end
        repeat (20) begin
            @(negedge clk_50M);
            if (LED === 1'b1) lit++;
        end
        checks++; if (lit != 0) begin errors++; $display("FAIL allfs_led: got %0d lit cycles want 0", lit); end
    endtask

    task automatic test_timeout_clear();
        int d, n = 0;
        begin_round(d);
        wait_go(d);
        while (done !== 1'b1 && n < 60) begin @(negedge clk_50M); n++; end
        checks++; if (cyc - t_go != 50) begin errors++; $display("FAIL timeout_cycle: got %0d want 50", cyc - t_go); end
        checks++; if (timeout !== 1'b1 || winner_valid !== 1'b0 || LED !== 1'b0 || CounterFlag !== 2'b01 || LED_InRuning !== 1'b0) begin
            errors++; $display("FAIL timeout_result: got to=%b wv=%b led=%b cf=%b run=%b want 1 0 0 01 0", timeout, winner_valid, LED, CounterFlag, LED_InRuning);
        end
        start = 1'b1;
        clear = 1'b1;
        #5 clear = 1'b0;
        repeat (5) @(negedge clk_50M);
        checks++; if (LED_InRuning !== 1'b0 || CounterFlag !== 2'b00 || timeout !== 1'b0) begin
            errors++; $display("FAIL held_start: got run=%b cf=%b to=%b want 0 00 0", LED_InRuning, CounterFlag, timeout);
        end
        start = 1'b0;
        begin_round(d);
        wait_go(d);
        repeat (3) @(negedge clk_50M);
        #5 clear = 1'b1;
        #1;
        checks++; if ({CounterFlag, LED, LED_InRuning, false_start, winner_valid, winner_id, react_cyc, timeout, done} !== '0) begin
            errors++; $display("FAIL clear_mid_go: got cf=%b led=%b run=%b fs=%b wv=%b want all 0", CounterFlag, LED, LED_InRuning, false_start, winner_valid);
        end
        @(negedge clk_50M);
        clear = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int d, k, n = 0, w, end_k;
            logic [3:0] fsm, gm, el;
            logic pressed;
            fsm = 4'($urandom_range(0, 14));
            gm = 4'($urandom_range(1, 15));
            k = $urandom_range(1, 50);
            pressed = ($urandom_range(0, 4) != 0);
            begin_round(d);
            if (fsm != 4'b0) press(fsm);
            wait_go(d);
            if (pressed) begin
                repeat (k - 1) @(negedge clk_50M);
                press(gm);
            end
            while (done !== 1'b1 && n < 60) begin @(negedge clk_50M); n++; end
            el = pressed ? (gm & ~fsm) : 4'b0;
            w = lowest(el);
            end_k = (w >= 0) ? k : 50;
            checks++; if (cyc - t_go != end_k) begin errors++; $display("FAIL rand_end r%0d: got %0d want %0d", r, cyc - t_go, end_k); end
            checks++; if (winner_valid !== (w >= 0) || timeout !== (w < 0) || false_start !== fsm) begin
                errors++; $display("FAIL rand_flags r%0d: got wv=%b to=%b fs=%b want %0b %0b %b", r, winner_valid, timeout, false_start, w >= 0, w < 0, fsm);
            end
            if (w >= 0) begin
                checks++; if (winner_id !== 2'(w) || react_cyc !== 32'(k)) begin
                    errors++; $display("FAIL rand_winner r%0d: got id=%0d react=%0d want %0d %0d", r, winner_id, react_cyc, w, k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_false_start();
        test_simultaneous();
        test_all_false();
        test_timeout_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reaction_arbiter.md
Name: reaction_arbiter

Overview:
- Multi-player reaction-timer controller for the 50 MHz board design. It generalises the single-player start/stop logic to PLAYERS independent stop buttons, with a parametrised random-delay window and a reaction timeout.
- Arms on start, waits a pseudo-random delay, then lights the go LED and measures the first valid reaction.
- Flags false starts per player and drives the downstream display counter through the existing CounterFlag encoding.

Parameters:
- PLAYERS, 4: number of stop buttons, 1..8.
- CNT_W, 32: width of the internal counters and of react_cyc.
- DELAY_MIN, 100000000: minimum arm-to-go delay in cycles (2 s at 50 MHz).
- DELAY_SPAN, 200000000: random span, >0; delay = DELAY_MIN + (lfsr mod DELAY_SPAN). DELAY_MIN+DELAY_SPAN must be < 2^CNT_W.
- TIMEOUT_CYC, 500000000: maximum GO duration before the round is abandoned.

Ports:
- clk_50M  in  1  system clock.
- clear  in  1  reset: asynchronous, active-high.
- start  in  1  round start; synchronous, debounced level; rising edge detected internally.
- stop  in  PLAYERS  per-player buttons; synchronous, debounced; rising edges detected internally.
- CounterFlag  out  2  display counter control: 00 clear, 01 stop/hold, 10 run.
- LED  out  1  go lamp.
- LED_InRuning  out  1  round in progress (ARM or GO).
- false_start  out  PLAYERS  sticky per-player false-start flags.
- winner_valid  out  1  winner_id and react_cyc are meaningful.
- winner_id  out  max(1,$clog2(PLAYERS))  index of the winning player.
- react_cyc  out  CNT_W  reaction time in cycles.
- timeout  out  1  round ended with no valid reaction.
- done  out  1  one-cycle pulse on entry to RESULT.

Behaviour:
Reset (clear high, asynchronous):
- State IDLE; all outputs 0; CounterFlag 00.
- Counters cleared; LFSR seeded to 32'h1.
- Edge-detector history registers set to 1, so a button held through reset release produces no edge.

Edge detection and timing:
- edge = input & ~prev; prev is updated every cycle.
- Each event acts on the first clock edge that samples the input high.
- LFSR: 32-bit Galois, taps for x^32+x^22+x^2+x+1. Advances every cycle in every state.

States:
- IDLE:
  - start edge: clear false_start, winner_valid, timeout and react_cyc.
  - Latch delay from the current LFSR value, counter = 0, CounterFlag 00, LED_InRuning 1, go to ARM.
- ARM:
  - counter increments each cycle.
  - stop edge on player p: false_start[p] = 1 (sticky).
  - All PLAYERS flagged: go to RESULT with winner_valid 0 and timeout 0; done pulses; CounterFlag 01; LED_InRuning 0.
  - If all players are flagged on the same edge the delay expires, RESULT wins.
  - Otherwise, on the D-th edge after entering ARM: go to GO, LED 1, CounterFlag 10, counter = 0.
  - The go lamp therefore rises exactly D cycles after the start edge.
- GO:
  - Stop edges from players with false_start set are ignored.
  - First edge from an eligible player, on the k-th edge after GO entry: react_cyc = k (minimum 1), winner_id = p, winner_valid 1.
  - On that edge: LED 0, CounterFlag 01, LED_InRuning 0, done pulse, go to RESULT.
  - Simultaneous eligible edges: lowest index wins.
  - Counter reaches TIMEOUT_CYC with no eligible stop: timeout 1, winner_valid 0, LED 0, CounterFlag 01, go to RESULT.
  - If a stop and the timeout coincide, the stop wins.
- RESULT:
  - All results held for display.
  - start edge: behaves as from IDLE (new round).
  - stop edges ignored.

Global rules:
- start edges during ARM or GO are ignored.
- clear asserted mid-round aborts immediately to the reset values.
- Counters never wrap: the parameter constraint guarantees counter < 2^CNT_W.

Decomposition:
- Package reaction_pkg:
  - state enum IDLE, ARM, GO, RESULT.
  - CounterFlag constants CF_CLEAR = 2'b00, CF_HOLD = 2'b01, CF_RUN = 2'b10.
  - LFSR tap constant.
- Sub-module lfsr32: enable-free Galois LFSR with async reset seed, output q[31:0].
- Edge detection stays inline.

Test Plan (PLAYERS = 4, DELAY_MIN = 10, DELAY_SPAN = 4, TIMEOUT_CYC = 50; the bench reference model tracks the LFSR):
1. clear pulse, then start edge: LED rises after exactly model D cycles, with D in 10..13; CounterFlag goes 00 then 10; LED_InRuning 1 throughout ARM/GO.
2. stop[2] edge 3 edges after GO entry: react_cyc = 3, winner_id = 2, winner_valid 1, done high for one cycle, CounterFlag 01, LED 0.
3. stop[1] edge during ARM, then stop[1] and stop[3] edges together in GO: false_start = 4'b0010, winner_id = 3.
4. stop[0] and stop[2] edges on the same GO edge: winner_id = 0.
5. All four stop edges during ARM: RESULT with winner_valid 0, timeout 0, LED never rises.
6. No stop in GO: timeout 1 at the 50th cycle; then start held high through clear pulse and release, no new round begins; clear mid-GO returns every output to 0 asynchronously.
